pid_driver: RTL and testbench
=============================

Name: pid_driver

Overview:
Master-side driver for the PID controller's register-write and iterate interface. Accepts a complete gain set (kp, ki, kd_1, kd_2) over a valid/ready handshake. Serialises the gains into four register writes on the controller's active-low write port. While enabled, it issues one-cycle iterate strobes at a programmable sample period. Sits between the host/config logic and the PID controller instance.

Parameters:
D_WIDTH, 32, width of gain data, reg_addr and reg_data.
PERIOD_WIDTH, 16, width of the sample-period input and internal counter.

Ports:
clock  in  1  system clock.
reset  in  1  synchronous, active-high reset.
cfg_valid  in  1  gain set presented.
cfg_ready  out  1  driver can accept a gain set.
cfg_kp  in  D_WIDTH  signed proportional gain, Q15.
cfg_ki  in  D_WIDTH  signed integral gain, Q15.
cfg_kd_1  in  D_WIDTH  signed derivative gain 1, Q15.
cfg_kd_2  in  D_WIDTH  signed derivative filter gain, Q15.
period  in  PERIOD_WIDTH  sample period in clock cycles, unsigned.
run  in  1  level; enables periodic iteration.
write_enable  out  1  active-low register write strobe to the controller.
reg_addr  out  D_WIDTH  register address: 0=kp, 1=ki, 2=kd_1, 3=kd_2.
reg_data  out  D_WIDTH  register write data.
iterate_enable  out  1  one-cycle iterate strobe to the controller.
cfg_done  out  1  one-cycle pulse after the final write of a set.
busy  out  1  high while in LOAD.

Behaviour:
- Single clock domain. All outputs are registered.
- Reset is synchronous, active-high. Reset values: write_enable=1, reg_addr=0, reg_data=0, iterate_enable=0, cfg_done=0, busy=0, cfg_ready=0. State=IDLE, write index=0, counter=0.
- cfg_ready=1 in IDLE and RUN. cfg_ready=0 in LOAD and during reset.
- FSM states: IDLE, LOAD, RUN.
  - IDLE: if cfg_valid&&cfg_ready, go to LOAD. Else if run, go to RUN.
  - LOAD: go to RUN if run is high in the cycle of the last write, else go to IDLE.
  - RUN: if cfg_valid&&cfg_ready, go to LOAD (reload takes priority). Else if !run, go to IDLE.
- Handshake acceptance (cfg_valid&&cfg_ready) captures all four gains into shadow registers in that same cycle. Inputs may change afterwards without effect.
- LOAD sequence:
  - Writes begin the cycle after acceptance.
  - Exactly 4 consecutive cycles of write_enable=0, with reg_addr=0..3 and reg_data set to kp, ki, kd_1, kd_2 in that order.
  - cfg_done=1 for one cycle, in the cycle immediately after the reg_addr=3 beat.
  - In that same cycle write_enable returns to 1 and reg_addr/reg_data return to 0.
  - busy=1 exactly during the 4 write beats.
- Outside LOAD: write_enable=1, reg_addr=0, reg_data=0.
- iterate_enable is never asserted during LOAD or IDLE.
- RUN timing:
  - period is latched on RUN entry as period_q; a latched value of 0 is treated as 1.
  - The counter starts at 0 on RUN entry and increments each RUN cycle.
  - When counter==period_q-1 and run is high: iterate_enable=1 next cycle and the counter wraps to 0.
  - Result: first strobe arrives period_q cycles after RUN entry, then one strobe every period_q cycles. period_q=1 gives a strobe every cycle.
- run deasserted during RUN: no strobe is issued from that cycle onward. The counter clears.
- Reload during RUN: counter clears, strobes stop for the LOAD window. RUN re-entry relatches period and restarts the count at 0.
- Reset mid-LOAD: the sequence aborts immediately with reset values and no cfg_done. The shadow gains are discarded.
- cfg_valid held high with cfg_ready=0 is ignored; there is no queueing.

Decomposition:
- Package pid_pkg holds:
  - address constants PID_ADDR_KP=0, PID_ADDR_KI=1, PID_ADDR_KD1=2, PID_ADDR_KD2=3;
  - enum pid_drv_state_t {IDLE, LOAD, RUN};
  - default D_WIDTH=32 and Q_BITS=15 constants shared with the controller.
- Sub-module pid_period_timer: counter with clear, enable and period inputs; produces the registered strobe; owns the period=0 rule.

Test Plan:
- Reset, then send gains kp=0x8000, ki=0x0100, kd_1=0x0040, kd_2=0x0000 with run=0 -> write_enable low for 4 cycles starting the cycle after acceptance, reg_addr 0,1,2,3 with the matching data; cfg_done pulses one cycle later; state IDLE; iterate_enable stays 0.
- period=5, run=1 from IDLE -> first iterate_enable 5 cycles after RUN entry, then every 5 cycles; 4 strobes in 20 cycles, each exactly 1 cycle wide.
- period=0 and period=1 -> iterate_enable high every cycle in RUN.
- Gain set accepted mid-RUN with period=8 -> strobes stop, 4 write beats occur, cfg_done pulses; first new strobe 8 cycles after RUN re-entry.
- Reset asserted on the 2nd write beat -> next cycle write_enable=1, reg_addr=0, busy=0, no cfg_done; cfg_ready=1 once reset is released.
- run dropped while counter=period_q-2 with period=4 -> no further iterate_enable; state IDLE next cycle; cfg_valid while busy gets cfg_ready=0 and is not captured.

Source files
------------

// File: rtl/pid_pkg.sv
// Shared constants and types for the PID controller and its register-write driver.
package pid_pkg;

   // Data width and fixed-point fraction bits shared with the controller core
   localparam int PID_D_WIDTH = 32;
   localparam int PID_Q_BITS  = 15;

   // Controller register map
   localparam int PID_ADDR_KP   = 0;
   localparam int PID_ADDR_KI   = 1;
   localparam int PID_ADDR_KD1  = 2;
   localparam int PID_ADDR_KD2  = 3;
   localparam int PID_NUM_GAINS = 4;

   // Driver sequencing states
   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      RUN
   } pid_drv_state_t;

endpackage

// File: rtl/pid_period_timer.sv
// Sample-period timer: counts RUN cycles and emits a registered one-cycle strobe
// every period_q cycles. A period of 0 is treated as 1 (strobe every cycle).
module pid_period_timer #(
   parameter int PERIOD_WIDTH = 16
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    clear,
   input  logic                    start,
   input  logic                    enable,
   input  logic [PERIOD_WIDTH-1:0] period,
   output logic                    strobe
);

   logic [PERIOD_WIDTH-1:0] period_q_reg;
   logic [PERIOD_WIDTH-1:0] count_reg;

   // Latch the period on start, then count and wrap while enabled; otherwise hold the count at 0
   always_ff @(posedge clock) begin
      if (reset) begin
         period_q_reg <= PERIOD_WIDTH'(1);
         count_reg    <= '0;
         strobe       <= 1'b0;
      end else if (clear) begin
         count_reg <= '0;
         strobe    <= 1'b0;
      end else if (start) begin
         period_q_reg <= (period == '0) ? PERIOD_WIDTH'(1) : period;
         count_reg    <= '0;
         strobe       <= 1'b0;
      end else if (enable) begin
         if (count_reg == period_q_reg - PERIOD_WIDTH'(1)) begin
            count_reg <= '0;
            strobe    <= 1'b1;
         end else begin
            count_reg <= count_reg + PERIOD_WIDTH'(1);
            strobe    <= 1'b0;
         end
      end else begin
         count_reg <= '0;
         strobe    <= 1'b0;
      end
   end

endmodule

// File: rtl/pid_driver.sv
// Master-side driver for the PID controller: accepts a gain set over valid/ready,
// serialises it into four active-low register writes, and issues periodic iterate
// strobes while run is high.
module pid_driver
   import pid_pkg::*;
#(
   parameter int D_WIDTH      = PID_D_WIDTH,
   parameter int PERIOD_WIDTH = 16
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    cfg_valid,
   output logic                    cfg_ready,
   input  logic [D_WIDTH-1:0]      cfg_kp,
   input  logic [D_WIDTH-1:0]      cfg_ki,
   input  logic [D_WIDTH-1:0]      cfg_kd_1,
   input  logic [D_WIDTH-1:0]      cfg_kd_2,
   input  logic [PERIOD_WIDTH-1:0] period,
   input  logic                    run,
   output logic                    write_enable,
   output logic [D_WIDTH-1:0]      reg_addr,
   output logic [D_WIDTH-1:0]      reg_data,
   output logic                    iterate_enable,
   output logic                    cfg_done,
   output logic                    busy
);

   pid_drv_state_t state_reg;
   logic [1:0]     beat_reg;
   logic [1:0]     beat_next;

   // Gains packed in register-address order so the beat index selects the data directly
   logic [PID_NUM_GAINS-1:0][D_WIDTH-1:0] gain_in;
   logic [PID_NUM_GAINS-1:0][D_WIDTH-1:0] shadow_reg;

   logic accept;
   logic last_beat;
   logic enter_run;
   logic stay_run;
   logic timer_clear;

   assign gain_in   = {cfg_kd_2, cfg_kd_1, cfg_ki, cfg_kp};
   assign accept    = cfg_valid && cfg_ready;
   assign beat_next = beat_reg + 2'd1;
   assign last_beat = (state_reg == LOAD) && (beat_reg == 2'd3);

   // RUN is entered from IDLE or at the end of a load; reload in RUN has priority over staying
   assign enter_run   = run && !accept && ((state_reg == IDLE) || last_beat);
   assign stay_run    = run && !accept && (state_reg == RUN);
   assign timer_clear = !(enter_run || stay_run);

   // Sequencer: handshake capture, write beats, and state transitions with registered outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg    <= IDLE;
         beat_reg     <= 2'd0;
         shadow_reg   <= '0;
         cfg_ready    <= 1'b0;
         write_enable <= 1'b1;
         reg_addr     <= '0;
         reg_data     <= '0;
         cfg_done     <= 1'b0;
         busy         <= 1'b0;
      end else begin
         cfg_done     <= 1'b0;
         write_enable <= 1'b1;
         reg_addr     <= '0;
         reg_data     <= '0;
         busy         <= 1'b0;
         cfg_ready    <= 1'b1;
         case (state_reg)
            IDLE, RUN: begin
               if (accept) begin
                  // First beat goes out straight from the inputs; the shadow covers the rest
                  shadow_reg   <= gain_in;
                  state_reg    <= LOAD;
                  beat_reg     <= 2'd0;
                  write_enable <= 1'b0;
                  reg_addr     <= D_WIDTH'(PID_ADDR_KP);
                  reg_data     <= cfg_kp;
                  busy         <= 1'b1;
                  cfg_ready    <= 1'b0;
               end else if ((state_reg == IDLE) && run) begin
                  state_reg <= RUN;
               end else if ((state_reg == RUN) && !run) begin
                  state_reg <= IDLE;
               end
            end
            LOAD: begin
               if (last_beat) begin
                  cfg_done  <= 1'b1;
                  state_reg <= run ? RUN : IDLE;
               end else begin
                  beat_reg     <= beat_next;
                  write_enable <= 1'b0;
                  reg_addr     <= D_WIDTH'(beat_next);
                  reg_data     <= shadow_reg[beat_next];
                  busy         <= 1'b1;
                  cfg_ready    <= 1'b0;
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   pid_period_timer #(
      .PERIOD_WIDTH(PERIOD_WIDTH)
   ) u_timer (
      .clock  (clock),
      .reset  (reset),
      .clear  (timer_clear),
      .start  (enter_run),
      .enable (stay_run),
      .period (period),
      .strobe (iterate_enable)
   );

endmodule

// File: tb/tb_pid_driver.sv
// Testbench for pid_driver: directed scenarios plus randomized traffic, every cycle
// compared against a behavioural model of the driver's transaction rules.
module tb_pid_driver;

   localparam int DW = 32;
   localparam int PW = 16;

   localparam int M_IDLE = 0;
   localparam int M_LOAD = 1;
   localparam int M_RUN  = 2;

   logic          clock;
   logic          reset;
   logic          cfg_valid;
   logic          cfg_ready;
   logic [DW-1:0] cfg_kp;
   logic [DW-1:0] cfg_ki;
   logic [DW-1:0] cfg_kd_1;
   logic [DW-1:0] cfg_kd_2;
   logic [PW-1:0] period;
   logic          run;
   logic          write_enable;
   logic [DW-1:0] reg_addr;
   logic [DW-1:0] reg_data;
   logic          iterate_enable;
   logic          cfg_done;
   logic          busy;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Behavioural model state
   int          m_mode   = M_IDLE;
   int          m_beat   = 0;
   int          m_t      = 0;
   int          m_p      = 1;
   bit          m_ready  = 0;
   bit          m_done   = 0;
   bit          m_strobe = 0;
   logic [DW-1:0] m_gain [4];

   pid_driver #(
      .D_WIDTH      (DW),
      .PERIOD_WIDTH (PW)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .cfg_valid      (cfg_valid),
      .cfg_ready      (cfg_ready),
      .cfg_kp         (cfg_kp),
      .cfg_ki         (cfg_ki),
      .cfg_kd_1       (cfg_kd_1),
      .cfg_kd_2       (cfg_kd_2),
      .period         (period),
      .run            (run),
      .write_enable   (write_enable),
      .reg_addr       (reg_addr),
      .reg_data       (reg_data),
      .iterate_enable (iterate_enable),
      .cfg_done       (cfg_done),
      .busy           (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   // Advance the model by one clock using the inputs currently applied
   task automatic model_next();
      bit acc;
      int p_in;
      p_in = (period == 0) ? 1 : int'(period);
      if (reset) begin
         m_mode = M_IDLE; m_beat = 0; m_t = 0;
         m_ready = 0; m_done = 0; m_strobe = 0;
         return;
      end
      acc      = cfg_valid && m_ready;
      m_strobe = (m_mode == M_RUN) && run && !acc && (((m_t + 1) % m_p) == 0);
      m_done   = 0;
      if (acc) begin
         $display("txn cycle=%0d accept kp=%h ki=%h kd1=%h kd2=%h", cyc, cfg_kp, cfg_ki, cfg_kd_1, cfg_kd_2);
         m_gain[0] = cfg_kp; m_gain[1] = cfg_ki; m_gain[2] = cfg_kd_1; m_gain[3] = cfg_kd_2;
         m_mode = M_LOAD; m_beat = 0;
      end else if (m_mode == M_LOAD) begin
         if (m_beat == 3) begin
            m_done = 1;
            if (run) begin m_mode = M_RUN; m_t = 0; m_p = p_in; end
            else m_mode = M_IDLE;
         end else begin
            m_beat++;
         end
      end else if (m_mode == M_IDLE) begin
         if (run) begin m_mode = M_RUN; m_t = 0; m_p = p_in; end
      end else begin
         if (!run) m_mode = M_IDLE;
         else m_t++;
      end
      m_ready = (m_mode != M_LOAD);
   endtask

   task automatic compare_all();
      bit ld;
      ld = (m_mode == M_LOAD);
      check_eq("write_enable",   64'(write_enable),   64'(!ld));
      check_eq("reg_addr",       64'(reg_addr),       ld ? 64'(m_beat) : 64'd0);
      check_eq("reg_data",       64'(reg_data),       ld ? 64'(m_gain[m_beat]) : 64'd0);
      check_eq("busy",           64'(busy),           64'(ld));
      check_eq("cfg_ready",      64'(cfg_ready),      64'(m_ready));
      check_eq("cfg_done",       64'(cfg_done),       64'(m_done));
      check_eq("iterate_enable", 64'(iterate_enable), 64'(m_strobe));
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         model_next();
         @(posedge clock);
         #1;
         cyc++;
         compare_all();
      end
   endtask

   task automatic rand_gains();
      cfg_kp = $urandom; cfg_ki = $urandom; cfg_kd_1 = $urandom; cfg_kd_2 = $urandom;
   endtask

   initial begin
      int scnt;
      for (int i = 0; i < 4; i++) m_gain[i] = '0;
      reset = 1'b1; cfg_valid = 1'b0; run = 1'b0; period = '0;
      cfg_kp = '0; cfg_ki = '0; cfg_kd_1 = '0; cfg_kd_2 = '0;
      step(3);
      reset = 1'b0;
      step(1);

      // Gain load with run low
      cfg_kp = 32'h8000; cfg_ki = 32'h0100; cfg_kd_1 = 32'h0040; cfg_kd_2 = 32'h0000;
      cfg_valid = 1'b1;
      step(1);
      cfg_valid = 1'b0;
      rand_gains();
      step(6);

      // period=5 from IDLE: count strobes across the 20 cycles after RUN entry
      period = 16'd5; run = 1'b1;
      step(1);
      period = 16'd3;
      scnt = 0;
      for (int i = 0; i < 20; i++) begin
         step(1);
         if (iterate_enable) scnt++;
      end
      check_eq("strobe_count_p5", 64'(scnt), 64'd4);
      run = 1'b0;
      step(2);

      // period 0 and 1: strobe every cycle
      period = 16'd0; run = 1'b1; step(6);
      run = 1'b0; step(2);
      period = 16'd1; run = 1'b1; step(6);
      run = 1'b0; step(2);

      // Reload mid-RUN with period 8
      period = 16'd8; run = 1'b1; step(10);
      rand_gains(); cfg_valid = 1'b1; step(1);
      cfg_valid = 1'b0; step(20);
      run = 1'b0; step(3);

      // Reset on the second write beat
      rand_gains(); cfg_valid = 1'b1; step(1);
      cfg_valid = 1'b0; step(1);
      reset = 1'b1; step(1);
      reset = 1'b0; step(3);

      // run dropped at counter = period_q-2 with period 4
      period = 16'd4; run = 1'b1; step(1);
      step(2);
      run = 1'b0; step(4);

      // cfg_valid held while busy is ignored
      rand_gains(); cfg_valid = 1'b1; step(1);
      for (int i = 0; i < 3; i++) begin rand_gains(); step(1); end
      cfg_valid = 1'b0; step(8);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         rand_gains();
         cfg_valid = ($urandom % 8) == 0;
         if (($urandom % 40) == 0) run = ~run;
         period = PW'($urandom % 7);
         reset  = ($urandom % 300) == 0;
         step(1);
      end
      reset = 1'b0; cfg_valid = 1'b0; run = 1'b0;
      step(8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
